scroll_addr_gen: RTL and testbench

SCROLL_ADDR_GEN -- requirements
Module: scroll_addr_gen

---
 rtl/scroll_pkg.sv | 15 +
 rtl/mod_add.sv | 19 +
 rtl/scroll_addr_gen.sv | 167 ++++++++++++++++
 tb/tb_scroll_addr_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
// Shared types and default sizing for the scrolling text-matrix address generator.
package scroll_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SCAN      = 2'd1,
        FRAME_END = 2'd2
    } scroll_state_t;

    localparam int DEF_ROWS            = 8;
    localparam int DEF_COLS            = 32;
    localparam int DEF_BUF_COLS        = 1024;
    localparam int DEF_FRAMES_PER_STEP = 4;

endpackage

// File: rtl/mod_add.sv
// (a + b) mod MOD for operands already below MOD; one extra bit avoids overflow
// when MOD is not a power of two.
module mod_add #(
    parameter int MOD = 1024,
    parameter int W   = $clog2(MOD)
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    logic [W:0] w_raw;
    logic [W:0] w_wrapped;

    assign w_raw     = {1'b0, i_a} + {1'b0, i_b};
    assign w_wrapped = w_raw - (W+1)'(MOD);
    assign o_sum     = (w_raw >= (W+1)'(MOD)) ? w_wrapped[W-1:0] : w_raw[W-1:0];

endmodule

// File: rtl/scroll_addr_gen.sv
// Walks a ROWS x COLS window over a circular text buffer, emitting one
// {buffer column, row} address per accepted beat; the window offset scrolls between frames.
module scroll_addr_gen
    import scroll_pkg::*;
#(
    parameter int ROWS            = DEF_ROWS,
    parameter int COLS            = DEF_COLS,
    parameter int BUF_COLS        = DEF_BUF_COLS,
    parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
    parameter int ROW_W           = $clog2(ROWS),
    parameter int COL_W           = $clog2(COLS),
    parameter int OFF_W           = $clog2(BUF_COLS)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_scroll_en,
    input  logic                   i_scroll_dir,
    input  logic                   i_offset_load,
    input  logic [OFF_W-1:0]       i_offset_in,
    input  logic                   i_addr_ready,
    output logic [OFF_W+ROW_W-1:0] o_addr,
    output logic                   o_addr_valid,
    output logic [ROW_W-1:0]       o_row_count,
    output logic [COL_W-1:0]       o_col_count,
    output logic [OFF_W-1:0]       o_offset,
    output logic                   o_frame_done
);

    localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    scroll_state_t r_state, w_state_next;

    logic [ROW_W-1:0]       r_row, w_row_next;
    logic [COL_W-1:0]       r_col, w_col_next;
    logic [OFF_W-1:0]       r_offset, w_offset_next;
    logic [FC_W-1:0]        r_frame_cnt, w_frame_cnt_next;
    logic                   r_pend;
    logic [OFF_W-1:0]       r_pend_val;
    logic [OFF_W+ROW_W-1:0] r_addr;

    logic                   w_accept;
    logic                   w_last_col;
    logic                   w_last_row;
    logic                   w_step_due;
    logic [OFF_W-1:0]       w_col_ext;
    logic [OFF_W-1:0]       w_buf_col;
    logic [OFF_W-1:0]       w_step_up;
    logic [OFF_W-1:0]       w_step_down;
    logic [OFF_W:0]         w_load_wide;
    logic [OFF_W:0]         w_load_sub;
    logic [OFF_W-1:0]       w_load_val;

    assign w_accept   = (r_state == SCAN) && i_addr_ready;
    assign w_last_col = (r_col == COL_W'(COLS - 1));
    assign w_last_row = (r_row == ROW_W'(ROWS - 1));
    assign w_step_due = (r_frame_cnt == FC_W'(FRAMES_PER_STEP - 1));

    // The address register is loaded from the coordinate that will be presented next cycle.
    assign w_col_ext = OFF_W'(w_col_next);

    mod_add #(.MOD(BUF_COLS), .W(OFF_W)) u_col_add (
        .i_a   (w_col_ext),
        .i_b   (r_offset),
        .o_sum (w_buf_col)
    );

    mod_add #(.MOD(BUF_COLS), .W(OFF_W)) u_step_add (
        .i_a   (r_offset),
        .i_b   (OFF_W'(1)),
        .o_sum (w_step_up)
    );

    assign w_step_down = (r_offset == '0) ? OFF_W'(BUF_COLS - 1) : (r_offset - OFF_W'(1));

    // offset_in is below 2*BUF_COLS, so one conditional subtract is a full modulo.
    assign w_load_wide = {1'b0, i_offset_in};
    assign w_load_sub  = w_load_wide - (OFF_W+1)'(BUF_COLS);
    assign w_load_val  = (w_load_wide >= (OFF_W+1)'(BUF_COLS)) ? w_load_sub[OFF_W-1:0]
                                                                : i_offset_in;

    always_comb begin
        w_state_next     = r_state;
        w_row_next       = r_row;
        w_col_next       = r_col;
        w_offset_next    = r_offset;
        w_frame_cnt_next = r_frame_cnt;
        case (r_state)
            IDLE: begin
                w_row_next = '0;
                w_col_next = '0;
                if (i_enable) begin
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                if (w_accept) begin
                    if (w_last_col) begin
                        w_col_next = '0;
                        if (w_last_row) begin
                            w_row_next   = '0;
                            w_state_next = FRAME_END;
                        end else begin
                            w_row_next = r_row + ROW_W'(1);
                        end
                    end else begin
                        w_col_next = r_col + COL_W'(1);
                    end
                end
            end
            FRAME_END: begin
                w_state_next = IDLE;
                w_row_next   = '0;
                w_col_next   = '0;
                // An explicit load overrides any scroll step due on this frame.
                if (r_pend) begin
                    w_offset_next    = r_pend_val;
                    w_frame_cnt_next = '0;
                end else if (i_scroll_en) begin
                    if (w_step_due) begin
                        w_frame_cnt_next = '0;
                        w_offset_next    = i_scroll_dir ? w_step_down : w_step_up;
                    end else begin
                        w_frame_cnt_next = r_frame_cnt + FC_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_offset    <= '0;
            r_frame_cnt <= '0;
            r_pend      <= 1'b0;
            r_pend_val  <= '0;
            r_addr      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_row       <= w_row_next;
            r_col       <= w_col_next;
            r_offset    <= w_offset_next;
            r_frame_cnt <= w_frame_cnt_next;
            r_addr      <= {w_buf_col, w_row_next};
            if (i_offset_load) begin
                r_pend     <= 1'b1;
                r_pend_val <= w_load_val;
            end else if (r_state == FRAME_END) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_addr       = r_addr;
    assign o_addr_valid = (r_state == SCAN);
    assign o_row_count  = r_row;
    assign o_col_count  = r_col;
    assign o_offset     = r_offset;
    assign o_frame_done = (r_state == FRAME_END);

endmodule

// File: tb/tb_scroll_addr_gen.sv
// Bench: three generators share one stimulus stream; instance 0 steps every 4 frames,
// instance 1 every frame, instance 2 every frame over a 1000-column (non power of two) buffer.
module tb_scroll_addr_gen;

    localparam int ROWS  = 8;
    localparam int COLS  = 32;
    localparam int ROW_W = 3;
    localparam int COL_W = 5;
    localparam int OFF_W = 10;
    localparam int AW    = OFF_W + ROW_W;
    localparam int BEATS = ROWS * COLS;
    localparam int NDUT  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             sen;
    logic             sdir;
    logic             ld;
    logic [OFF_W-1:0] ld_val;
    logic             rdy;

    logic [AW-1:0]    a_o   [NDUT];
    logic             v_o   [NDUT];
    logic [ROW_W-1:0] row_o [NDUT];
    logic [COL_W-1:0] col_o [NDUT];
    logic [OFF_W-1:0] off_o [NDUT];
    logic             fd_o  [NDUT];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        scroll_addr_gen #(
            .ROWS            (ROWS),
            .COLS            (COLS),
            .BUF_COLS        ((gi == 2) ? 1000 : 1024),
            .FRAMES_PER_STEP ((gi == 0) ? 4 : 1)
        ) u_dut (
            .i_clk         (clk),
            .i_reset       (rst),
            .i_enable      (en),
            .i_scroll_en   (sen),
            .i_scroll_dir  (sdir),
            .i_offset_load (ld),
            .i_offset_in   (ld_val),
            .i_addr_ready  (rdy),
            .o_addr        (a_o[gi]),
            .o_addr_valid  (v_o[gi]),
            .o_row_count   (row_o[gi]),
            .o_col_count   (col_o[gi]),
            .o_offset      (off_o[gi]),
            .o_frame_done  (fd_o[gi])
        );
    end

    // Reference model: offset bookkeeping per instance, addresses from beat index.
    int m_fps  [NDUT] = '{4, 1, 1};
    int m_bufc [NDUT] = '{1024, 1024, 1000};
    int m_off  [NDUT] = '{0, 0, 0};
    int m_cnt  [NDUT] = '{0, 0, 0};
    int m_pval [NDUT] = '{0, 0, 0};
    bit m_pend = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int exp_addr(input int k, input int off, input int bufc);
        return (((k % COLS) + off) % bufc) * ROWS + (k / COLS);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_off[i] = 0;
            m_cnt[i] = 0;
        end
        m_pend = 1'b0;
    endfunction

    function automatic void model_frame_end();
        for (int i = 0; i < NDUT; i++) begin
            if (m_pend) begin
                m_off[i] = m_pval[i];
                m_cnt[i] = 0;
            end else if (sen) begin
                m_cnt[i]++;
                if (m_cnt[i] == m_fps[i]) begin
                    m_cnt[i] = 0;
                    m_off[i] = sdir ? (m_off[i] + m_bufc[i] - 1) % m_bufc[i]
                                    : (m_off[i] + 1) % m_bufc[i];
                end
            end
        end
        m_pend = 1'b0;
    endfunction

    // Runs one frame from IDLE. abort_at >= 0 asserts reset when that beat is presented.
    task automatic run_frame(input bit do_load, input int load_val, input int stall_pct,
                             input int abort_at);
        int  k;
        int  guard;
        int  load_at;
        bit  load_done;
        load_done = 1'b0;
        load_at   = do_load ? $urandom_range((abort_at >= 0) ? abort_at - 1 : BEATS - 2, 1) : -1;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        k = 0;
        guard = 0;
        while (k < BEATS && guard < 20 * BEATS) begin
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                for (int i = 0; i < NDUT; i++) begin
                    chk($sformatf("rst_addr%0d", i), a_o[i], 0);
                    chk($sformatf("rst_valid%0d", i), v_o[i], 0);
                    chk($sformatf("rst_row%0d", i), row_o[i], 0);
                    chk($sformatf("rst_col%0d", i), col_o[i], 0);
                    chk($sformatf("rst_off%0d", i), off_o[i], 0);
                    chk($sformatf("rst_fd%0d", i), fd_o[i], 0);
                end
                model_reset();
                ld = 1'b0;
                en = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("abort_no_fd", fd_o[0], 0);
                    chk("abort_idle_valid", v_o[0], 0);
                end
                return;
            end
            for (int i = 0; i < NDUT; i++) begin
                chk($sformatf("valid%0d", i), v_o[i], 1);
                chk($sformatf("addr%0d_k%0d", i, k), a_o[i], exp_addr(k, m_off[i], m_bufc[i]));
                chk($sformatf("off_scan%0d", i), off_o[i], m_off[i]);
            end
            chk("row", row_o[0], k / COLS);
            chk("col", col_o[0], k % COLS);
            chk("fd_scan", fd_o[0], 0);
            ld = 1'b0;
            if (k == load_at && !load_done) begin
                ld        = 1'b1;
                ld_val    = OFF_W'(load_val);
                load_done = 1'b1;
                m_pend    = 1'b1;
                for (int i = 0; i < NDUT; i++) m_pval[i] = load_val % m_bufc[i];
            end
            rdy = ($urandom_range(99) >= stall_pct);
            en  = 1'($urandom_range(1));
            if (rdy) k++;
            @(negedge clk);
            guard++;
        end
        ld = 1'b0;
        en = 1'b0;
        if (k < BEATS) begin
            chk("beat_timeout", k, BEATS);
            return;
        end
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("fd_pulse%0d", i), fd_o[i], 1);
            chk($sformatf("valid_fe%0d", i), v_o[i], 0);
            chk($sformatf("off_fe%0d", i), off_o[i], m_off[i]);
        end
        model_frame_end();
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("fd_idle%0d", i), fd_o[i], 0);
            chk($sformatf("off_new%0d", i), off_o[i], m_off[i]);
        end
        chk("row_idle", row_o[0], 0);
        chk("col_idle", col_o[0], 0);
    endtask

    typedef struct {
        bit load;
        int val;
        bit sen;
        bit dir;
        int stall;
        int e0;
        int e1;
        int e2;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{0, 0,    1, 0, 0,  0,    1,    1};
        tbl[1]  = '{0, 0,    1, 0, 10, 0,    2,    2};
        tbl[2]  = '{0, 0,    1, 0, 0,  0,    3,    3};
        tbl[3]  = '{0, 0,    1, 0, 20, 1,    4,    4};
        tbl[4]  = '{0, 0,    0, 0, 30, 1,    4,    4};
        tbl[5]  = '{1, 1020, 1, 0, 40, 1020, 1020, 20};
        tbl[6]  = '{0, 0,    1, 0, 0,  1020, 1021, 21};
        tbl[7]  = '{1, 995,  1, 0, 0,  995,  995,  995};
        tbl[8]  = '{0, 0,    1, 0, 25, 995,  996,  996};
        tbl[9]  = '{1, 0,    0, 0, 0,  0,    0,    0};
        tbl[10] = '{0, 0,    1, 1, 0,  0,    1023, 999};
        tbl[11] = '{0, 0,    1, 1, 15, 0,    1022, 998};
        tbl[12] = '{0, 0,    1, 1, 0,  0,    1021, 997};
        tbl[13] = '{1, 500,  1, 1, 30, 500,  500,  500};
        tbl[14] = '{0, 0,    1, 1, 0,  500,  499,  499};

        rst = 1'b1; en = 1'b0; sen = 1'b0; sdir = 1'b0;
        ld = 1'b0; ld_val = '0; rdy = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("init_addr%0d", i), a_o[i], 0);
            chk($sformatf("init_valid%0d", i), v_o[i], 0);
            chk($sformatf("init_off%0d", i), off_o[i], 0);
            chk($sformatf("init_fd%0d", i), fd_o[i], 0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_wait_valid", v_o[0], 0);
        end

        for (int t = 0; t < 15; t++) begin
            sen  = tbl[t].sen;
            sdir = tbl[t].dir;
            run_frame(tbl[t].load, tbl[t].val, tbl[t].stall, -1);
            chk($sformatf("tbl%0d_off0", t), off_o[0], tbl[t].e0);
            chk($sformatf("tbl%0d_off1", t), off_o[1], tbl[t].e1);
            chk($sformatf("tbl%0d_off2", t), off_o[2], tbl[t].e2);
            repeat ($urandom_range(2)) @(negedge clk);
        end

        for (int r = 0; r < 8; r++) begin
            sen  = 1'($urandom_range(1));
            sdir = 1'($urandom_range(1));
            run_frame(($urandom_range(99) < 30), $urandom_range(1023), $urandom_range(60), -1);
        end

        // Abort mid-frame with a pending load; neither may survive the reset.
        sen = 1'b1; sdir = 1'b0;
        run_frame(1'b1, 777, 0, 100);
        run_frame(1'b0, 0, 20, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
